adt7420_i2c_master: RTL and testbench

ADT7420_I2C_MASTER -- requirements
Module: adt7420_i2c_master

---
 rtl/adt7420_pkg.sv | 12 +
 rtl/adt7420_i2c_master.sv | 94 +++++++++
 tb/tb_adt7420_i2c_master.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/adt7420_pkg.sv
// Shared definitions for the ADT7420 temperature poller: FSM states and bus timing constants.
package adt7420_pkg;

  typedef enum logic [3:0] {
    POWER_UP, START, ADDR, ADDR_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP, WAIT
  } state_t;

  localparam int         PHASES           = 4;
  localparam int         WAIT_CYCLES      = 256;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;

endpackage

// File: rtl/adt7420_i2c_master.sv
// Single-master I2C poller: repeatedly reads the 16-bit temperature register of an ADT7420
// (power-on pointer 0x00) and publishes the last successfully addressed reading.
module adt7420_i2c_master
  import adt7420_pkg::*;
#(
  parameter logic [11:0] POWER_UP_TIME = 12'd1950,
  parameter logic [6:0]  DEV_ADDR      = DEFAULT_DEV_ADDR
) (
  input  logic        clk_200kHz,
  input  logic        rst_n,
  output logic        scl,
  inout  wire         sda,
  output logic [15:0] temperature
);

  localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, 1'b1};
  localparam logic [11:0] WAIT_LAST = 12'(WAIT_CYCLES - 1);
  localparam logic [11:0] BIT_LAST  = 12'(PHASES - 1);
  localparam logic [11:0] BYTE_LAST = 12'(8 * PHASES - 1);

  state_t      state, nxt;
  logic [11:0] cnt;
  logic        last;
  logic [1:0]  phase;
  logic [2:0]  bitIdx;
  logic        sclHigh;
  logic        sdaLow;
  logic        nackBit;
  logic [15:0] rxSh;

  // One counter serves every state: within byte states cnt[1:0] is the phase, cnt[4:2] the bit.
  assign phase   = cnt[1:0];
  assign bitIdx  = cnt[4:2];
  assign sclHigh = (phase == 2'd1) || (phase == 2'd2);

  always_comb begin
    last = 1'b0;
    nxt  = state;
    case (state)
      POWER_UP: begin last = (cnt == POWER_UP_TIME - 12'd1); nxt = START;    end
      START:    begin last = (cnt == 12'd2);                 nxt = ADDR;     end
      ADDR:     begin last = (cnt == BYTE_LAST);             nxt = ADDR_ACK; end
      ADDR_ACK: begin last = (cnt == BIT_LAST);  nxt = nackBit ? STOP : RD_MSB; end
      RD_MSB:   begin last = (cnt == BYTE_LAST);             nxt = M_ACK;    end
      M_ACK:    begin last = (cnt == BIT_LAST);              nxt = RD_LSB;   end
      RD_LSB:   begin last = (cnt == BYTE_LAST);             nxt = M_NACK;   end
      M_NACK:   begin last = (cnt == BIT_LAST);              nxt = STOP;     end
      STOP:     begin last = (cnt == BIT_LAST);              nxt = WAIT;     end
      WAIT:     begin last = (cnt == WAIT_LAST);             nxt = START;    end
      default:  begin last = 1'b1;                           nxt = POWER_UP; end
    endcase
  end

  always_ff @(posedge clk_200kHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= POWER_UP;
      cnt         <= '0;
      nackBit     <= 1'b1;
      rxSh        <= '0;
      temperature <= '0;
    end else begin
      if (last) begin
        state <= nxt;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 12'd1;
      end
      // Sample at the end of phase 2, after SCL has been high for two cycles.
      if (phase == 2'd2) begin
        if (state == ADDR_ACK) nackBit <= sda;
        if (state == RD_MSB || state == RD_LSB) rxSh <= {rxSh[14:0], sda};
      end
      // Only the full-read path reaches STOP through M_NACK; a NACKed address keeps the old value.
      if (state == M_NACK && last) temperature <= rxSh;
    end
  end

  always_comb begin
    scl    = 1'b1;
    sdaLow = 1'b0;
    case (state)
      START:    begin scl = (cnt != 12'd2); sdaLow = 1'b1; end
      ADDR:     begin scl = sclHigh; sdaLow = !ADDR_BYTE[3'd7 - bitIdx]; end
      ADDR_ACK, RD_MSB, RD_LSB, M_NACK: scl = sclHigh;
      M_ACK:    begin scl = sclHigh; sdaLow = 1'b1; end
      // Pull SDA low with SCL low, raise SCL, then release SDA with SCL high.
      STOP:     begin scl = (phase != 2'd0); sdaLow = (phase < 2'd2); end
      default:  begin scl = 1'b1; sdaLow = 1'b0; end
    endcase
  end

  assign sda = sdaLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_adt7420_i2c_master.sv
// Bench for adt7420_i2c_master: ADT7420 slave model on a pulled-up SDA, bus-rule monitor,
// table of poll transactions plus power-up and mid-read reset sequences.
module tb_adt7420_i2c_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl;
  wire         sda;
  logic [15:0] temperature;
  logic        slvLow = 1'b0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = slvLow ? 1'b0 : 1'bz;

  adt7420_i2c_master dut (
    .clk_200kHz (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda        (sda),
    .temperature(temperature)
  );

  typedef struct {
    logic        present;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [15:0] expTemp;
    int          expRise;  // SCL rising edges seen before STOP, including the STOP's own rise
    int          expLen;   // cycles from START edge to STOP edge
  } vec_t;

  vec_t vecs [5];

  int nCmp = 0, nErr = 0;
  int cyc;
  int startCnt = 0, stopCnt = 0, startCyc = 0, stopCyc = 0;
  int riseCnt = 0, stopRise = 0, viol = 0, sclLowPre = 0;
  logic prevScl = 1'b1, prevSda = 1'b1, inXfer = 1'b0, acked = 1'b0, seenStart = 1'b0;
  logic mAck = 1'b1, mNack = 1'b0;
  logic [7:0] addrByte = '0;
  logic cfgPresent = 1'b0;
  logic [7:0] cfgMsb = '0, cfgLsb = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and bus monitor, sampled on the falling clock edge away from DUT updates.
  always @(negedge clk) begin
    logic s, d;
    int   n;
    s = scl;
    d = sda;
    if (!rst_n) begin
      slvLow = 1'b0; inXfer = 1'b0; riseCnt = 0; seenStart = 1'b0; sclLowPre = 0;
    end else begin
      if (slvLow && d) begin
        viol++; $display("FAIL sdaHighWhileSlaveLow: sda=%b at cyc %0d", d, cyc);
      end
      if (!seenStart && !s) sclLowPre++;
      if (d != prevSda) begin
        if (prevScl && s) begin
          if (!d) begin
            if (inXfer) begin viol++; $display("FAIL startInXfer: sda fell at cyc %0d", cyc); end
            inXfer = 1'b1; seenStart = 1'b1; riseCnt = 0; addrByte = '0; acked = 1'b0;
            mAck = 1'b1; mNack = 1'b0; startCnt++; startCyc = cyc;
          end else begin
            if (!inXfer) begin viol++; $display("FAIL stopIdle: sda rose at cyc %0d", cyc); end
            inXfer = 1'b0; stopRise = riseCnt; stopCnt++; stopCyc = cyc; slvLow = 1'b0;
          end
        end else if (prevScl != s) begin
          viol++; $display("FAIL sdaWithScl: sda %b scl %b->%b at cyc %0d", d, prevScl, s, cyc);
        end
      end
      if (!prevScl && s && inXfer) begin
        if (riseCnt < 8)        addrByte = {addrByte[6:0], d};
        else if (riseCnt == 17) mAck = d;
        else if (riseCnt == 26) mNack = d;
        riseCnt++;
      end
      if (prevScl && !s && inXfer) begin
        n = riseCnt;
        slvLow = 1'b0;
        if (n == 8) begin
          acked  = cfgPresent && (addrByte == 8'h97);
          slvLow = acked;
        end else if (acked && n >= 9 && n <= 16) begin
          slvLow = !cfgMsb[16 - n];
        end else if (acked && n >= 18 && n <= 25) begin
          slvLow = !cfgLsb[25 - n];
        end
      end
    end
    prevScl = s;
    prevSda = d;
  end

  task automatic waitStart(input string name, input int budget);
    int old = startCnt;
    int n = 0;
    while (startCnt == old && n < budget) begin @(negedge clk); #1; n++; end
    chk({name, "StartSeen"}, startCnt != old, 1);
  endtask

  task automatic waitStop(input string name, input int budget);
    int old = stopCnt;
    int n = 0;
    while (stopCnt == old && n < budget) begin @(negedge clk); #1; n++; end
    chk({name, "StopSeen"}, stopCnt != old, 1);
  endtask

  task automatic setCfg(input vec_t v);
    cfgPresent = v.present; cfgMsb = v.msb; cfgLsb = v.lsb;
  endtask

  initial begin
    int n;
    vec_t rv;
    vecs[0] = '{1'b1, 8'h0C, 8'h80, 16'h0C80, 28, 113};
    vecs[1] = '{1'b1, 8'hF3, 8'h80, 16'hF380, 28, 113};
    vecs[2] = '{1'b0, 8'hAA, 8'h55, 16'hF380, 10, 41};
    vecs[3] = '{1'b1, 8'h00, 8'h08, 16'h0008, 28, 113};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 16'h8001, 28, 113};

    setCfg(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    chk("rstScl", scl, 1);
    chk("rstSda", sda, 1);
    chk("rstTemp", temperature, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    waitStart("pwrUp", 5000);
    chk("pwrUpStartCyc", startCyc, 1950);
    chk("pwrUpSclLow", sclLowPre, 0);
    chk("pwrUpTemp", temperature, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      waitStop($sformatf("v%0d", i), 600);
      chk($sformatf("v%0d addr", i), addrByte, 8'h97);
      chk($sformatf("v%0d temp", i), temperature, vecs[i].expTemp);
      chk($sformatf("v%0d rises", i), stopRise, vecs[i].expRise);
      chk($sformatf("v%0d len", i), stopCyc - startCyc, vecs[i].expLen);
      if (vecs[i].present) begin
        chk($sformatf("v%0d mAck", i), mAck, 0);
        chk($sformatf("v%0d mNack", i), mNack, 1);
      end
      if (i < 4) setCfg(vecs[i + 1]);
      else       setCfg(vecs[0]);
      n = stopCyc;
      waitStart($sformatf("v%0d next", i), 600);
      // STOP edge is two cycles before WAIT begins; WAIT then lasts 256 cycles.
      chk($sformatf("v%0d gap", i), startCyc - n, 258);
    end

    // Reset in the middle of the MSB byte.
    n = 0;
    while (riseCnt < 12 && n < 500) begin @(negedge clk); #1; n++; end
    chk("midRdMsbReached", riseCnt, 12);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midRstTemp", temperature, 16'h0000);
    chk("midRstScl", scl, 1);
    chk("midRstSda", sda, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitStart("postRst", 5000);
    chk("postRstStartCyc", startCyc, 1950);
    chk("postRstSclLow", sclLowPre, 0);
    chk("postRstTempPre", temperature, 16'h0000);
    waitStop("postRst", 600);
    chk("postRstTemp", temperature, 16'h0C80);

    chk("busViolations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
